// File: rtl/step_pulse_shaper.sv
// step_pulse_shaper
// Conditions the raw divided step clock from the angle-to-step generator into
// clean STEP/DIR/EN pins for an external stepper driver. Incoming step edges
// are synchronised, queued in a saturating pending counter and re-emitted as
// pulses with guaranteed high time, low time and DIR setup time. The absolute
// signed microstep position is tracked alongside.

module step_pulse_shaper #(
  parameter int SIZE           = 32,
  parameter int PULSE_HIGH_CYC = 25,
  parameter int PULSE_LOW_CYC  = 25,
  parameter int DIR_SETUP_CYC  = 5,
  parameter int PEND_W         = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic                   dir_i,
  input  logic                   step_i,
  input  logic                   clear_pos_i,
  output logic                   step_o,
  output logic                   dir_o,
  output logic                   en_no,
  output logic signed [SIZE-1:0] position_o,
  output logic [PEND_W-1:0]      pending_o,
  output logic                   overflow_o,
  output logic                   busy_o
);

  // The shared down-counter only ever holds (longest phase - 1).
  localparam int MAX_HL  = (PULSE_HIGH_CYC > PULSE_LOW_CYC) ? PULSE_HIGH_CYC : PULSE_LOW_CYC;
  localparam int MAX_CYC = (MAX_HL > DIR_SETUP_CYC) ? MAX_HL : DIR_SETUP_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] HIGH_LOAD  = CNT_W'(PULSE_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD   = CNT_W'(PULSE_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(DIR_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    DIR_SETUP,
    HIGH,
    LOW
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             step_d;
  logic             dir_d;
  logic             launch;
  logic             pos_step;

  logic             sync_s1;
  logic             sync_s2;
  logic             sync_s3;
  logic             step_rise;
  logic             step_accept;
  logic             pend_full;
  logic             pend_nonzero;

  // Two-flop synchroniser for the asynchronous step clock plus a history flop for edge detection
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_s1 <= 1'b0;
      sync_s2 <= 1'b0;
      sync_s3 <= 1'b0;
    end else begin
      sync_s1 <= step_i;
      sync_s2 <= sync_s1;
      sync_s3 <= sync_s2;
    end
  end

  assign step_rise    = sync_s2 & ~sync_s3;
  assign step_accept  = step_rise & enable_i;
  assign pend_full    = &pending_o;
  assign pend_nonzero = |pending_o;
  assign busy_o       = (state_q != IDLE);

  // Driver enable pin simply follows the upstream enable, inverted, one cycle late
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      en_no <= 1'b1;
    end else begin
      en_no <= ~enable_i;
    end
  end

  // Saturating queue of accepted-but-unemitted steps; a dropped edge at saturation is remembered until reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_o  <= '0;
      overflow_o <= 1'b0;
    end else if (!enable_i) begin
      pending_o <= '0;
    end else if (step_accept && !launch) begin
      if (pend_full) begin
        overflow_o <= 1'b1;
      end else begin
        pending_o <= pending_o + PEND_W'(1);
      end
    end else if (launch && !step_accept) begin
      pending_o <= pending_o - PEND_W'(1);
    end
  end

  // Next-state logic: direction setup, pulse high and pulse low all share one down-counter
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    step_d   = step_o;
    dir_d    = dir_o;
    launch   = 1'b0;
    pos_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i && pend_nonzero) begin
          if (dir_i != dir_o) begin
            dir_d   = dir_i;
            cnt_d   = SETUP_LOAD;
            state_d = DIR_SETUP;
          end else begin
            launch  = 1'b1;
            step_d  = 1'b1;
            cnt_d   = HIGH_LOAD;
            state_d = HIGH;
          end
        end
      end
      DIR_SETUP: begin
        if (cnt_q == '0) begin
          if (enable_i && pend_nonzero) begin
            launch  = 1'b1;
            step_d  = 1'b1;
            cnt_d   = HIGH_LOAD;
            state_d = HIGH;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          step_d   = 1'b0;
          pos_step = 1'b1;
          cnt_d    = LOW_LOAD;
          state_d  = LOW;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      LOW: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with registered STEP/DIR pins; reset drops STEP immediately, even mid-pulse
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_o  <= 1'b0;
      dir_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_o  <= step_d;
      dir_o   <= dir_d;
    end
  end

  // Position moves one microstep as each pulse ends; an explicit clear wins over a coincident step
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      position_o <= '0;
    end else if (clear_pos_i) begin
      position_o <= '0;
    end else if (pos_step) begin
      if (dir_o) begin
        position_o <= position_o + SIZE'(1);
      end else begin
        position_o <= position_o - SIZE'(1);
      end
    end
  end

endmodule

// File: tb/tb_step_pulse_shaper.sv
// tb_step_pulse_shaper
// Directed bench for step_pulse_shaper. Three instances share clock and most
// inputs: dut_a uses default parameters, dut_b a 2-bit pending counter, and
// dut_c minimum (1-cycle) timings with a 4-bit position for wrap checks.
// Each instance has its own enable so only the instance under test reacts.

module tb_step_pulse_shaper;

  typedef struct {
    logic              dir;
    logic signed [31:0] pos;
  } exp_t;

  logic clk;
  logic rst_n;
  logic dir_i;
  logic step_i;
  logic clear_pos;
  logic en_a;
  logic en_b;
  logic en_c;

  logic              step_a;
  logic              dir_a;
  logic              en_n_a;
  logic signed [31:0] pos_a;
  logic [7:0]        pending_a;
  logic              overflow_a;
  logic              busy_a;

  logic              step_b;
  logic              dir_b;
  logic              en_n_b;
  logic signed [31:0] pos_b;
  logic [1:0]        pending_b;
  logic              overflow_b;
  logic              busy_b;

  logic              step_c;
  logic              dir_c;
  logic              en_n_c;
  logic [3:0]        pos_c;
  logic [7:0]        pending_c;
  logic              overflow_c;
  logic              busy_c;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  exp_t exp_q[$];
  exp_t exp_pop;
  int   a_rise_q[$];
  logic mon_a_en = 1'b0;
  logic mon_c_en = 1'b0;
  logic a_prev = 1'b0;
  logic a_seen_fall = 1'b0;
  int   a_high_cnt = 0;
  int   a_low_cnt = 0;
  logic b_prev = 1'b0;
  int   b_rise_cnt = 0;
  logic c_prev = 1'b0;
  int   c_high_cnt = 0;

  step_pulse_shaper dut_a (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .enable_i    (en_a),
    .dir_i       (dir_i),
    .step_i      (step_i),
    .clear_pos_i (clear_pos),
    .step_o      (step_a),
    .dir_o       (dir_a),
    .en_no       (en_n_a),
    .position_o  (pos_a),
    .pending_o   (pending_a),
    .overflow_o  (overflow_a),
    .busy_o      (busy_a)
  );

  step_pulse_shaper #(.PEND_W(2)) dut_b (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .enable_i    (en_b),
    .dir_i       (dir_i),
    .step_i      (step_i),
    .clear_pos_i (clear_pos),
    .step_o      (step_b),
    .dir_o       (dir_b),
    .en_no       (en_n_b),
    .position_o  (pos_b),
    .pending_o   (pending_b),
    .overflow_o  (overflow_b),
    .busy_o      (busy_b)
  );

  step_pulse_shaper #(
    .SIZE           (4),
    .PULSE_HIGH_CYC (1),
    .PULSE_LOW_CYC  (1),
    .DIR_SETUP_CYC  (1),
    .PEND_W         (8)
  ) dut_c (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .enable_i    (en_c),
    .dir_i       (dir_i),
    .step_i      (step_i),
    .clear_pos_i (clear_pos),
    .step_o      (step_c),
    .dir_o       (dir_c),
    .en_no       (en_n_c),
    .position_o  (pos_c),
    .pending_o   (pending_c),
    .overflow_o  (overflow_c),
    .busy_o      (busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count used to time-stamp pulse rising edges
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic step_val, input logic dir_val);
    step_i = step_val;
    dir_i  = dir_val;
  endtask

  task automatic do_reset();
    mon_a_en  = 1'b0;
    mon_c_en  = 1'b0;
    en_a      = 1'b0;
    en_b      = 1'b0;
    en_c      = 1'b0;
    clear_pos = 1'b0;
    applyStimulus(1'b0, 1'b0);
    exp_q.delete();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  // Scoreboard monitor for dut_a: measures each pulse and pops its expected direction/position at the falling edge
  always @(negedge clk) begin
    if (!mon_a_en) begin
      a_seen_fall = 1'b0;
    end else if (step_a && !a_prev) begin
      if (a_seen_fall) checkOutput("a_low_min", (a_low_cnt >= 25), 1);
      a_rise_q.push_back(cyc);
      a_high_cnt = 1;
    end else if (step_a) begin
      a_high_cnt++;
    end else if (a_prev) begin
      checkOutput("a_high_width", a_high_cnt, 25);
      checkOutput("a_pulse_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        exp_pop = exp_q.pop_front();
        checkOutput("a_pulse_dir", dir_a, exp_pop.dir);
        checkOutput("a_pulse_pos", pos_a, exp_pop.pos);
      end
      a_seen_fall = 1'b1;
      a_low_cnt   = 1;
    end else begin
      a_low_cnt++;
    end
    a_prev = step_a;
  end

  // Pulse counter for dut_b
  always @(negedge clk) begin
    if (step_b && !b_prev) b_rise_cnt++;
    b_prev = step_b;
  end

  // High-width checker for the minimum-timing instance dut_c
  always @(negedge clk) begin
    if (mon_c_en && !step_c && c_prev) checkOutput("c_high_width", c_high_cnt, 1);
    if (step_c) c_high_cnt = c_prev ? c_high_cnt + 1 : 1;
    c_prev = step_c;
  end

  initial begin
    int   lat;
    int   tog;
    int   peak;
    int   n0;
    int   b0;

    // Reset values
    rst_n     = 1'b0;
    en_a      = 1'b0;
    en_b      = 1'b0;
    en_c      = 1'b0;
    clear_pos = 1'b0;
    applyStimulus(1'b0, 1'b0);
    tick(3);
    checkOutput("rst_step", step_a, 0);
    checkOutput("rst_dir", dir_a, 0);
    checkOutput("rst_en_n", en_n_a, 1);
    checkOutput("rst_pos", pos_a, 0);
    checkOutput("rst_pending", pending_a, 0);
    checkOutput("rst_overflow", overflow_a, 0);
    checkOutput("rst_busy", busy_a, 0);
    rst_n = 1'b1;
    tick(1);

    // Enable pin has one cycle of latency
    en_a = 1'b1;
    checkOutput("en_n_before_edge", en_n_a, 1);
    tick(1);
    checkOutput("en_n_after_edge", en_n_a, 0);

    // Single step, dir 0, 10-cycle wide input
    $display("[TB] single step");
    mon_a_en = 1'b1;
    exp_q.push_back('{1'b0, -32'sd1});
    applyStimulus(1'b1, 1'b0);
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      tick(1);
      if (i == 10) applyStimulus(1'b0, 1'b0);
      if (i == 3) checkOutput("t1_pending_inc", pending_a, 1);
      if (i == 4) checkOutput("t1_pending_dec", pending_a, 0);
      if (step_a && lat == 0) lat = i;
    end
    checkOutput("t1_latency", lat, 4);
    checkOutput("t1_pos", pos_a, -1);
    checkOutput("t1_pending_end", pending_a, 0);
    checkOutput("t1_busy_end", busy_a, 0);
    checkOutput("t1_sb_drained", exp_q.size(), 0);

    // Burst of four edges six cycles apart
    $display("[TB] burst");
    do_reset();
    en_a = 1'b1;
    tick(1);
    mon_a_en = 1'b1;
    n0 = a_rise_q.size();
    for (int k = 1; k <= 4; k++) exp_q.push_back('{1'b0, -32'(k)});
    peak = 0;
    for (int i = 0; i < 215; i++) begin
      applyStimulus((i < 24) && ((i % 6) < 3), 1'b0);
      tick(1);
      if (int'(pending_a) > peak) peak = int'(pending_a);
    end
    checkOutput("t2_pending_peak", (peak == 3 || peak == 4), 1);
    checkOutput("t2_pulse_count", a_rise_q.size() - n0, 4);
    if (a_rise_q.size() >= n0 + 4) begin
      for (int k = 1; k < 4; k++) checkOutput("t2_rise_period", a_rise_q[n0+k] - a_rise_q[n0+k-1], 51);
    end
    checkOutput("t2_pos", pos_a, -4);
    checkOutput("t2_pending_end", pending_a, 0);
    checkOutput("t2_sb_drained", exp_q.size(), 0);

    // Direction change after prior steps
    $display("[TB] direction change");
    exp_q.push_back('{1'b1, -32'sd3});
    applyStimulus(1'b1, 1'b1);
    tog = 0;
    lat = 0;
    for (int i = 1; i <= 70; i++) begin
      tick(1);
      if (i == 3) applyStimulus(1'b0, 1'b1);
      if (dir_a && tog == 0) tog = i;
      if (step_a && lat == 0) lat = i;
    end
    checkOutput("t3_dir_toggle", tog, 4);
    checkOutput("t3_step_after_dir", lat - tog, 5);
    checkOutput("t3_pos", pos_a, -3);
    checkOutput("t3_sb_drained", exp_q.size(), 0);

    // Saturation of a 2-bit pending counter
    $display("[TB] saturation");
    do_reset();
    en_b = 1'b1;
    tick(1);
    b0 = b_rise_cnt;
    for (int i = 0; i < 260; i++) begin
      applyStimulus((i < 28) && ((i % 4) < 2), 1'b0);
      tick(1);
      if (i == 30) begin
        checkOutput("t4_pending_sat", pending_b, 3);
        checkOutput("t4_overflow_set", overflow_b, 1);
        checkOutput("t4_busy", busy_b, 1);
      end
    end
    checkOutput("t4_pulse_count", b_rise_cnt - b0, 4);
    checkOutput("t4_overflow_sticky", overflow_b, 1);
    checkOutput("t4_pending_end", pending_b, 0);
    checkOutput("t4_pos", pos_b, -4);

    // Enable drop five cycles into a pulse with two steps still pending
    $display("[TB] enable drop");
    do_reset();
    en_a = 1'b1;
    tick(1);
    mon_a_en = 1'b1;
    exp_q.push_back('{1'b0, -32'sd1});
    n0 = a_rise_q.size();
    for (int i = 0; i < 120; i++) begin
      applyStimulus((i < 6) && ((i % 2) == 0), 1'b0);
      tick(1);
      if (i == 8) begin
        checkOutput("t5_pending_before_drop", pending_a, 2);
        checkOutput("t5_high_before_drop", step_a, 1);
        en_a = 1'b0;
      end
      if (i == 9) begin
        checkOutput("t5_en_n_after_drop", en_n_a, 1);
        checkOutput("t5_pending_flushed", pending_a, 0);
      end
    end
    checkOutput("t5_pulse_count", a_rise_q.size() - n0, 1);
    checkOutput("t5_pos", pos_a, -1);
    checkOutput("t5_busy_end", busy_a, 0);
    checkOutput("t5_sb_drained", exp_q.size(), 0);

    // Reset asserted in the middle of a high phase
    $display("[TB] reset mid-pulse");
    mon_a_en = 1'b0;
    en_a = 1'b1;
    applyStimulus(1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (i == 3) applyStimulus(1'b0, 1'b0);
    end
    checkOutput("t6_in_high", step_a, 1);
    rst_n = 1'b0;
    tick(1);
    checkOutput("t6_step_dropped", step_a, 0);
    checkOutput("t6_pos_cleared", pos_a, 0);
    checkOutput("t6_idle", busy_a, 0);
    rst_n = 1'b1;
    tick(1);

    // Position clear coincident with the high-to-low edge
    $display("[TB] clear position");
    mon_a_en = 1'b1;
    exp_q.push_back('{1'b0, -32'sd1});
    exp_q.push_back('{1'b0, 32'sd0});
    applyStimulus(1'b1, 1'b0);
    for (int i = 1; i <= 60; i++) begin
      tick(1);
      if (i == 3) applyStimulus(1'b0, 1'b0);
    end
    checkOutput("t7_pos_before_clear", pos_a, -1);
    applyStimulus(1'b1, 1'b0);
    for (int i = 1; i <= 60; i++) begin
      tick(1);
      if (i == 3) applyStimulus(1'b0, 1'b0);
      if (i == 28) clear_pos = 1'b1;
      if (i == 29) begin
        clear_pos = 1'b0;
        checkOutput("t7_clear_priority", pos_a, 0);
        checkOutput("t7_fell", step_a, 0);
      end
    end
    checkOutput("t7_pos_end", pos_a, 0);
    checkOutput("t7_sb_drained", exp_q.size(), 0);

    // Minimum timings and position wrap on the 4-bit instance
    $display("[TB] minimum timing and wrap");
    do_reset();
    en_c = 1'b1;
    tick(1);
    mon_c_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 1'b1);
      lat = 0;
      for (int j = 1; j <= 8; j++) begin
        tick(1);
        if (j == 2) applyStimulus(1'b0, 1'b1);
        if (step_c && lat == 0) lat = j;
      end
      if (k == 1) checkOutput("c_latency_dir_change", lat, 5);
      if (k == 2) checkOutput("c_latency", lat, 4);
      if (k == 7) checkOutput("c_pos_max", pos_c, 4'h7);
      if (k == 8) checkOutput("c_pos_wrap", pos_c, 4'h8);
    end
    checkOutput("c_dir", dir_c, 1);
    checkOutput("c_pending_end", pending_c, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/step_pulse_shaper.md
Name: step_pulse_shaper

Overview:
- Sits directly downstream of the angle-to-step generator and drives the external stepper driver's STEP/DIR/EN pins.
- Synchronises the raw divided step clock into clk_i and counts its rising edges into a saturating pending-step counter.
- Re-emits each step as a clean pulse with guaranteed minimum high time, low time and DIR setup time.
- Tracks absolute signed microstep position.

Parameters:
- SIZE, 32, width of position counter
- PULSE_HIGH_CYC, 25, step_o high time in clk_i cycles (1 us at 25 MHz)
- PULSE_LOW_CYC, 25, minimum step_o low time after each pulse
- DIR_SETUP_CYC, 5, cycles dir_o must be stable before step_o rises
- PEND_W, 8, width of pending-step counter

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  synchronous active-low reset
- enable_i  in  1  motion enable from upstream
- dir_i  in  1  requested direction (1 = positive)
- step_i  in  1  raw step clock from the step generator; asynchronous to clk_i phase
- clear_pos_i  in  1  synchronous clear of position_o
- step_o  out  1  conditioned STEP pin
- dir_o  out  1  conditioned DIR pin
- en_no  out  1  driver enable, active low
- position_o  out  SIZE  signed two's-complement microstep position
- pending_o  out  PEND_W  steps accepted but not yet emitted
- overflow_o  out  1  sticky: a step edge was dropped at saturation
- busy_o  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst_ni low at a clk_i edge):
  - step_o=0, dir_o=0, en_no=1, position_o=0, pending_o=0, overflow_o=0, busy_o=0.
  - Sync flops are cleared and state is IDLE.
  - Reset mid-pulse drops step_o on that same edge; no remaining pulse time is honoured.
- Input sync:
  - step_i passes through two flops (s1, s2) plus a history flop s3.
  - A rising edge is s2 & ~s3.
- en_no is registered as ~enable_i, one cycle latency.
- Pending counter:
  - A rising edge while enable_i=1 increments the counter.
  - A pulse launch (IDLE→HIGH transition) decrements it.
  - Increment and decrement in the same cycle leave it unchanged.
  - Increment at all-ones: the counter holds and overflow_o sets.
  - overflow_o clears only on reset.
  - Edges while enable_i=0 are ignored.
  - When enable_i=0, the counter is forced to 0.
- FSM states: IDLE, DIR_SETUP, HIGH, LOW. One down-counter cnt is shared by DIR_SETUP, HIGH and LOW.
  - IDLE, when enable_i=1 and pending≠0:
    - If dir_i≠dir_o: dir_o<=dir_i, cnt<=DIR_SETUP_CYC-1, go to DIR_SETUP.
    - Otherwise: step_o<=1, decrement pending, cnt<=PULSE_HIGH_CYC-1, go to HIGH.
  - DIR_SETUP:
    - When cnt==0: launch the pulse exactly as in IDLE (the pending decrement happens here).
    - If pending reached 0 due to disable, return to IDLE instead.
  - HIGH:
    - When cnt==0: step_o<=0, cnt<=PULSE_LOW_CYC-1, go to LOW.
    - In the same cycle, position_o += 1 if dir_o=1, else -= 1.
  - LOW: when cnt==0, go to IDLE.
- Pulse timing:
  - Minimum step period is PULSE_HIGH_CYC+PULSE_LOW_CYC+1 cycles.
  - Latency from the first clk_i edge sampling step_i=1 to step_o=1 is 3 cycles when no direction change and pending was 0.
  - With a direction change, latency is 3+DIR_SETUP_CYC cycles.
- dir_o changes only in IDLE, so it never changes during HIGH or LOW.
- Deasserting enable_i mid-operation:
  - An in-progress HIGH/LOW completes normally, so no runt pulses occur, and position still updates.
  - pending is flushed and no new pulse launches.
- Position:
  - position_o wraps modulo 2^SIZE.
  - clear_pos_i forces 0 and takes priority over a coincident ±1 update.
- Parameters must be ≥1; the bench checks the values 1 and the defaults.

Test Plan:
- Single step, defaults, dir_i=0 after reset: one 10-cycle-wide step_i high.
  - step_o rises 3 cycles later and stays high 25 cycles, then low ≥25.
  - position_o=-1 and pending_o returns to 0.
- Burst: 4 step_i edges spaced 6 cycles apart, dir_i=0.
  - pending_o peaks at 3 or 4.
  - Four pulses each 25 high, rising edges exactly 51 cycles apart; position_o=-4.
- Direction change: after prior steps, set dir_i=1 and send one edge.
  - dir_o toggles, then step_o rises exactly 5 cycles later.
  - position_o increments by 1.
- Saturation with PEND_W=2: 6 rapid edges while the FSM is busy.
  - pending_o holds at 3 and overflow_o=1 persists.
  - Exactly 4 pulses are emitted (1 launched plus 3 pending).
- Enable drop: clear enable_i 5 cycles into a HIGH phase with pending=2.
  - The pulse completes its full 25 high cycles.
  - pending_o=0, no further pulses, en_no=1 one cycle after the drop.
- Reset and clear:
  - rst_ni low mid-HIGH: next edge shows step_o=0, position_o=0, state IDLE.
  - clear_pos_i coincident with the HIGH→LOW edge leaves position_o=0.
  - From position_o=0x7FFFFFFF, one positive step wraps to 0x80000000.
